// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - two-master single-access arbiter for the byte-lane data RAM
// Optional build macro: ARB_ROUND_ROBIN_EN (alternate grants on ties instead of master 0 priority).
module data_ram_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_stall,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  localparam logic [WAIT_W-1:0] WAIT_SAT = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [WAIT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic              starve0, starve1;

  assign starve0  = (cnt0_q >= WAIT_LIM);
  assign starve1  = (cnt1_q >= WAIT_LIM);
  assign m0_stall = m0_req & ~m0_ack;

  // Grant state, last successful owner and starvation counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  // A master that requests while not owning the RAM has waited one more cycle
  always_comb begin
    cnt0_d = '0;
    cnt1_d = '0;
    if (m0_req && state_q != OWN0) begin
      cnt0_d = (cnt0_q == WAIT_SAT) ? cnt0_q : cnt0_q + WAIT_ONE;
    end
    if (m1_req && state_q != OWN1) begin
      cnt1_d = (cnt1_q == WAIT_SAT) ? cnt1_q : cnt1_q + WAIT_ONE;
    end
  end

  // Grant decision in IDLE; one-cycle RAM access steering in OWN0/OWN1
  always_comb begin
    state_d      = IDLE;
    last_owner_d = last_owner_q;
    ram_ce       = 1'b0;
    ram_we       = 1'b0;
    ram_sel      = '0;
    ram_addr     = '0;
    ram_wdata    = '0;
    m0_ack       = 1'b0;
    m0_rdata     = '0;
    m1_ack       = 1'b0;
    m1_rdata     = '0;
    unique case (state_q)
      IDLE: begin
        if (starve0) begin
          state_d = OWN0;
        end else if (starve1) begin
          state_d = OWN1;
        end else if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = last_owner_q ? OWN0 : OWN1;
`else
          state_d = OWN0;
`endif
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        // A dropped request is an abandoned grant: no access, no ack
        if (m0_req) begin
          ram_ce       = 1'b1;
          ram_we       = m0_we;
          ram_sel      = m0_sel;
          ram_addr     = m0_addr;
          ram_wdata    = m0_wdata;
          m0_ack       = 1'b1;
          m0_rdata     = m0_we ? 32'h0 : ram_rdata;
          last_owner_d = 1'b0;
        end
      end
      OWN1: begin
        if (m1_req) begin
          ram_ce       = 1'b1;
          ram_we       = m1_we;
          ram_sel      = m1_sel;
          ram_addr     = m1_addr;
          ram_wdata    = m1_wdata;
          m1_ack       = 1'b1;
          m1_rdata     = m1_we ? 32'h0 : ram_rdata;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - self-checking bench for data_ram_arbiter with RAM model and reference model
`timescale 1ns/1ps
module tb_data_ram_arbiter;
  localparam int MAX_WAIT = 8;
  localparam int WSAT     = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_we, m0_ack, m0_stall;
  logic [3:0]  m0_sel;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack;
  logic [3:0]  m1_sel;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  data_ram_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Environment RAM: combinational read, byte-lane write on posedge, bench preload port
  logic [31:0] mem [0:15];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_data;
  assign ram_rdata = mem[ram_addr[5:2]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (ram_ce && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  // Reference model: who holds the RAM this cycle, how long each master has waited
  logic [31:0] ref_mem [0:15];
  int          r_owner, r_last, r_w0, r_w1;
  logic        exp_ack0, exp_ack1, exp_ce, exp_we, exp_stall;
  logic [3:0]  exp_sel;
  logic [31:0] exp_addr, exp_wdata, exp_rdata0, exp_rdata1;
  int          n_vec, n_err;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic predict();
    #1;
    exp_ack0   = (r_owner == 1) && m0_req;
    exp_ack1   = (r_owner == 2) && m1_req;
    exp_stall  = m0_req && !exp_ack0;
    exp_ce     = exp_ack0 || exp_ack1;
    exp_we     = 1'b0; exp_sel = 4'h0; exp_addr = 32'h0; exp_wdata = 32'h0;
    exp_rdata0 = 32'h0; exp_rdata1 = 32'h0;
    if (exp_ack0) begin
      exp_we = m0_we; exp_sel = m0_sel; exp_addr = m0_addr; exp_wdata = m0_wdata;
      if (!m0_we) exp_rdata0 = ref_mem[m0_addr[5:2]];
    end
    if (exp_ack1) begin
      exp_we = m1_we; exp_sel = m1_sel; exp_addr = m1_addr; exp_wdata = m1_wdata;
      if (!m1_we) exp_rdata1 = ref_mem[m1_addr[5:2]];
    end
  endtask

  task automatic advance();
    int nxt, nw0, nw1;
    if (exp_ack0 && m0_we) ref_mem[m0_addr[5:2]] = merge(ref_mem[m0_addr[5:2]], m0_wdata, m0_sel);
    if (exp_ack1 && m1_we) ref_mem[m1_addr[5:2]] = merge(ref_mem[m1_addr[5:2]], m1_wdata, m1_sel);
    nw0 = (m0_req && r_owner != 1) ? ((r_w0 < WSAT) ? r_w0 + 1 : WSAT) : 0;
    nw1 = (m1_req && r_owner != 2) ? ((r_w1 < WSAT) ? r_w1 + 1 : WSAT) : 0;
    if (r_owner != 0) nxt = 0;
    else if (r_w0 >= MAX_WAIT) nxt = 1;
    else if (r_w1 >= MAX_WAIT) nxt = 2;
    else if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      nxt = (r_last == 0) ? 2 : 1;
`else
      nxt = 1;
`endif
    end
    else if (m0_req) nxt = 1;
    else if (m1_req) nxt = 2;
    else nxt = 0;
    if (exp_ack0) r_last = 0;
    if (exp_ack1) r_last = 1;
    r_owner = nxt; r_w0 = nw0; r_w1 = nw1;
  endtask

  task automatic model_reset();
    r_owner = 0; r_last = 1; r_w0 = 0; r_w1 = 0;
  endtask

  task automatic set_idle();
    m0_req = 0; m0_we = 0; m0_sel = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_sel = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle(); set_idle(); predict(); advance();
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    next_cycle(); set_idle();
    pl_en = 1'b1; pl_idx = idx[3:0]; pl_data = d; ref_mem[idx] = d;
    predict(); advance();
  endtask

  task automatic rand_fields(output logic we, output logic [3:0] sel, output logic [31:0] addr, output logic [31:0] wd);
    logic [3:0] w;
    we = 1'($urandom_range(0, 1)); sel = 4'($urandom); w = 4'($urandom_range(0, 15));
    addr = {26'h0, w, 2'b00}; wd = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b0; pl_en = 1'b0;
    set_idle();
    m0_req = 1; m0_we = 1; m0_sel = 4'hf; m0_addr = 32'h10; m0_wdata = 32'hdeadbeef;
    m1_req = 1; m1_we = 1; m1_sel = 4'hf; m1_addr = 32'h20; m1_wdata = 32'hcafef00d;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); pl_en = 1'b1; pl_idx = i[3:0]; pl_data = $urandom; ref_mem[i] = pl_data;
    end
    @(negedge clk); pl_en = 1'b0;
    #1;
    n_vec++; if ({ram_ce, ram_we, ram_sel} !== 6'h0) begin n_err++; $display("FAIL reset_ctrl: got %b expected 000000", {ram_ce, ram_we, ram_sel}); end
    n_vec++; if ({ram_addr, ram_wdata} !== 64'h0) begin n_err++; $display("FAIL reset_bus: got %h expected 0", {ram_addr, ram_wdata}); end
    n_vec++; if ({m0_ack, m1_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks: got %b expected 00", {m0_ack, m1_ack}); end
    n_vec++; if ({m0_rdata, m1_rdata} !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata}); end
    n_vec++; if (m0_stall !== 1'b1) begin n_err++; $display("FAIL reset_stall_hi: got %b expected 1", m0_stall); end
    m0_req = 0; #1;
    n_vec++; if (m0_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall_lo: got %b expected 0", m0_stall); end
    @(negedge clk); rst = 1'b1; set_idle(); model_reset();
    predict(); advance();
  endtask

  task automatic test_m0_read();
    preload(4, 32'hA1B2C3D4);
    next_cycle(); m0_req = 1; m0_we = 0; m0_sel = 4'hf; m0_addr = 32'h10; predict();
    n_vec++; if ({m0_ack, m0_stall} !== 2'b01) begin n_err++; $display("FAIL m0rd_wait: ack,stall got %b expected 01", {m0_ack, m0_stall}); end
    advance();
    next_cycle(); predict();
    n_vec++; if ({m0_ack, m0_stall, ram_ce} !== 3'b101) begin n_err++; $display("FAIL m0rd_ack: ack,stall,ce got %b expected 101", {m0_ack, m0_stall, ram_ce}); end
    n_vec++; if (m0_rdata !== 32'hA1B2C3D4) begin n_err++; $display("FAIL m0rd_data: got %h expected a1b2c3d4", m0_rdata); end
    advance();
    next_cycle(); set_idle(); predict();
    n_vec++; if ({ram_ce, m0_stall, m0_ack} !== 3'b000) begin n_err++; $display("FAIL m0rd_after: ce,stall,ack got %b expected 000", {ram_ce, m0_stall, m0_ack}); end
    advance();
  endtask

  task automatic test_m1_write_read();
    logic [31:0] old;
    old = ref_mem[8];
    next_cycle(); m1_req = 1; m1_we = 1; m1_sel = 4'b0011; m1_addr = 32'h20; m1_wdata = 32'h11223344; predict();
    n_vec++; if ({ram_ce, m1_ack} !== 2'b00) begin n_err++; $display("FAIL m1wr_idle: ce,ack got %b expected 00", {ram_ce, m1_ack}); end
    advance();
    next_cycle(); predict();
    n_vec++; if ({m1_ack, ram_ce, ram_we, ram_sel} !== 7'b1110011) begin n_err++; $display("FAIL m1wr_ack: got %b expected 1110011", {m1_ack, ram_ce, ram_we, ram_sel}); end
    advance();
    next_cycle(); m1_we = 0; m1_sel = 4'hf; m1_wdata = 0; predict();
    n_vec++; if ({ram_ce, m1_ack} !== 2'b00) begin n_err++; $display("FAIL m1rd_idle: ce,ack got %b expected 00", {ram_ce, m1_ack}); end
    advance();
    next_cycle(); predict();
    n_vec++; if ({m1_ack, m1_rdata} !== {1'b1, old[31:16], 16'h3344}) begin n_err++; $display("FAIL m1rd_data: ack,data got %b %h expected 1 %h", m1_ack, m1_rdata, {old[31:16], 16'h3344}); end
    advance();
    idle_cycles(1);
  endtask

  task automatic test_contention();
    int m0_before, last, cur;
    bit seen1, alt_ok;
    m0_before = 0; last = -1; seen1 = 0; alt_ok = 1;
    idle_cycles(2);
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      if (c == 0 || m0_ack) begin m0_req = 1; m0_we = 0; m0_sel = 4'hf; m0_addr = {26'h0, 4'($urandom), 2'b00}; end
      if (c == 0 || m1_ack) begin m1_req = 1; m1_we = 0; m1_sel = 4'hf; m1_addr = {26'h0, 4'($urandom), 2'b00}; end
      predict();
      n_vec++; if ({m0_ack, m1_ack} !== {exp_ack0, exp_ack1}) begin n_err++; $display("FAIL contend_acks c=%0d: got %b expected %b", c, {m0_ack, m1_ack}, {exp_ack0, exp_ack1}); end
      n_vec++; if (m0_ack && m1_ack) begin n_err++; $display("FAIL contend_both c=%0d: got 11 expected at most one ack", c); end
      if (m1_ack) seen1 = 1;
      if (m0_ack && !seen1) m0_before++;
      if (m0_ack || m1_ack) begin cur = m1_ack ? 1 : 0; if (cur == last) alt_ok = 0; last = cur; end
      advance();
    end
`ifdef ARB_ROUND_ROBIN_EN
    n_vec++; if (!alt_ok) begin n_err++; $display("FAIL contend_alternate: got repeated owner expected alternation"); end
`else
    n_vec++; if (m0_before !== 4 || !seen1) begin n_err++; $display("FAIL contend_starve: m0 acks before m1 got %0d (m1 seen %0d) expected 4 (1)", m0_before, seen1); end
`endif
    idle_cycles(2);
  endtask

  task automatic test_abandon();
    logic [31:0] old;
    old = ref_mem[12];
    next_cycle(); m1_req = 1; m1_we = 1; m1_sel = 4'hf; m1_addr = 32'h30; m1_wdata = ~old; predict(); advance();
    next_cycle(); set_idle(); predict();
    n_vec++; if ({ram_ce, ram_we, m1_ack} !== 3'b000) begin n_err++; $display("FAIL abandon_own: ce,we,ack got %b expected 000", {ram_ce, ram_we, m1_ack}); end
    advance();
    next_cycle(); m1_req = 1; m1_we = 0; m1_sel = 4'hf; m1_addr = 32'h30; predict();
    n_vec++; if (m1_ack !== 1'b0) begin n_err++; $display("FAIL abandon_idle: ack got %b expected 0", m1_ack); end
    advance();
    next_cycle(); predict();
    n_vec++; if ({m1_ack, m1_rdata} !== {1'b1, old}) begin n_err++; $display("FAIL abandon_ram: ack,data got %b %h expected 1 %h", m1_ack, m1_rdata, old); end
    advance();
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] old;
    old = ref_mem[13];
    next_cycle(); m0_req = 1; m0_we = 1; m0_sel = 4'hf; m0_addr = 32'h34; m0_wdata = ~old; predict(); advance();
    next_cycle(); predict();
    n_vec++; if ({m0_ack, ram_we} !== 2'b11) begin n_err++; $display("FAIL rstw_own: ack,we got %b expected 11", {m0_ack, ram_we}); end
    #1 rst = 1'b0; #1;
    n_vec++; if ({ram_ce, ram_we, m0_ack, m1_ack, ram_addr, ram_wdata} !== 68'h0) begin n_err++; $display("FAIL rstw_outputs: got %h expected 0", {ram_ce, ram_we, m0_ack, m1_ack, ram_addr, ram_wdata}); end
    @(posedge clk); #1;
    n_vec++; if (mem[13] !== old) begin n_err++; $display("FAIL rstw_nocommit: ram got %h expected %h", mem[13], old); end
    @(negedge clk); rst = 1'b1; set_idle(); model_reset(); predict(); advance();
    next_cycle(); m0_req = 1; m0_we = 0; m0_sel = 4'hf; m0_addr = 32'h34; predict();
    n_vec++; if (m0_ack !== 1'b0) begin n_err++; $display("FAIL rstw_idle: ack got %b expected 0", m0_ack); end
    advance();
    next_cycle(); predict();
    n_vec++; if ({m0_ack, m0_rdata} !== {1'b1, old}) begin n_err++; $display("FAIL rstw_read: ack,data got %b %h expected 1 %h", m0_ack, m0_rdata, old); end
    advance();
    idle_cycles(1);
  endtask

  task automatic test_random();
    logic we; logic [3:0] sel; logic [31:0] addr, wd;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      if (!m0_req || m0_ack) begin
        rand_fields(we, sel, addr, wd);
        m0_req = ($urandom_range(0, 99) < 60); m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wd;
      end
      if (!m1_req || m1_ack) begin
        rand_fields(we, sel, addr, wd);
        m1_req = ($urandom_range(0, 99) < 60); m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wd;
      end
      predict();
      n_vec++; if ({m0_ack, m1_ack, m0_stall, ram_ce} !== {exp_ack0, exp_ack1, exp_stall, exp_ce}) begin n_err++; $display("FAIL rnd_ctrl c=%0d: got %b expected %b", c, {m0_ack, m1_ack, m0_stall, ram_ce}, {exp_ack0, exp_ack1, exp_stall, exp_ce}); end
      n_vec++; if ({ram_we, ram_sel, ram_addr, ram_wdata} !== {exp_we, exp_sel, exp_addr, exp_wdata}) begin n_err++; $display("FAIL rnd_bus c=%0d: got %h expected %h", c, {ram_we, ram_sel, ram_addr, ram_wdata}, {exp_we, exp_sel, exp_addr, exp_wdata}); end
      n_vec++; if ({m0_rdata, m1_rdata} !== {exp_rdata0, exp_rdata1}) begin n_err++; $display("FAIL rnd_rdata c=%0d: got %h expected %h", c, {m0_rdata, m1_rdata}, {exp_rdata0, exp_rdata1}); end
      n_vec++; if (m0_ack && m1_ack) begin n_err++; $display("FAIL rnd_both c=%0d: got 11 expected at most one ack", c); end
      advance();
    end
    idle_cycles(2);
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (mem[i] !== ref_mem[i]) begin n_err++; $display("FAIL rnd_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    test_reset();
    test_m0_read();
    test_m1_write_read();
    test_contention();
    test_abandon();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Two-master arbiter in front of the word-organised, byte-lane data RAM: combinational read, write on posedge, 4-bit byte select.
- Master 0 is the CPU MEM stage; master 1 is a secondary port (DMA / debug loader).
- Grants one single-cycle access at a time, drives the RAM control/address/data, and returns read data and ack to the owner.
- Raises a stall request to the pipeline while the CPU waits.

Parameters:
- MAX_WAIT, 8, consecutive cycles a requesting master may lose arbitration before it is force-granted (1..255).
- WAIT_W, 8, width of each starvation counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- m0_req  input  1  CPU access request; held with its fields stable until m0_ack
- m0_we  input  1  1 = write, 0 = read
- m0_sel  input  4  byte-lane enables, bit3 = data[31:24]
- m0_addr  input  32  byte address
- m0_wdata  input  32  write data
- m0_rdata  output  32  read data, valid while m0_ack = 1
- m0_ack  output  1  access performed this cycle
- m0_stall  output  1  pipeline stall request = m0_req & ~m0_ack
- m1_req, m1_we, m1_sel, m1_addr, m1_wdata, m1_rdata, m1_ack  same as the m0 equivalents, for master 1
- ram_ce  output  1  chip enable to RAM
- ram_we  output  1  write enable to RAM
- ram_sel  output  4  byte selects to RAM
- ram_addr  output  32  address to RAM
- ram_wdata  output  32  write data to RAM
- ram_rdata  input  32  combinational read data from RAM

Behaviour:
- Reset (rst = 0, async):
  - state = IDLE, last_owner = 1, both starvation counters = 0.
  - All outputs 0: ram_ce disabled, ram_we disabled, ram_sel = 0, addr/wdata/rdata = 0, acks = 0.
  - m0_stall follows m0_req combinationally.
- FSM states: IDLE, OWN0, OWN1. Grant is registered.
- In IDLE, at posedge:
  - starvation: if cnt0 >= MAX_WAIT go OWN0; else if cnt1 >= MAX_WAIT go OWN1; cnt0 checked first;
  - else both requesting: go OWN0 (fixed priority; see Optional Feature);
  - else single requester: go to its OWN state;
  - else stay IDLE.
- In OWNx (exactly one cycle):
  - If mx_req = 1: ram_ce = 1, ram_we/sel/addr/wdata = mx fields combinationally, mx_ack = 1, mx_rdata = ram_rdata when mx_we = 0, otherwise 0. The write commits at the closing edge.
  - If mx_req = 0 (abandoned): ram_ce = 0, no ack, no access.
  - Next state is always IDLE. last_owner <= x only when the access was performed.
- Latency: request seen at edge N, ack in cycle N+1. Minimum 2 cycles per access. Peak throughput is one access per 2 cycles total.
- Non-owner outputs: rdata = 0, ack = 0.
- RAM outputs are 0 in IDLE.
- Starvation counters:
  - cntx increments, saturating at 2^WAIT_W−1, on each posedge where mx_req = 1 and state != OWNx.
  - cntx clears when mx_ack = 1 or mx_req = 0.
- Simultaneous requests with both counters saturated: master 0 wins, then master 1 next.
- A write and a read to the same address from different masters are serialised in grant order; no reordering.
- The arbiter never asserts both acks in one cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both request in IDLE and neither is starved, grant the master != last_owner (alternates).
- Undefined: master 0 always wins ties; master 1 is protected only by the MAX_WAIT starvation rule.

Test Plan:
- Reset, then m0 read addr 0x10 with RAM word 0xA1B2C3D4 → m0_ack high in the cycle after the req edge, m0_rdata = 0xA1B2C3D4; m0_stall high 1 cycle then low.
- m1 write addr 0x20, sel 4'b0011, wdata 0x11223344, then m1 read of 0x20 → the read's m1_ack cycle returns 0x????3344 (lanes 0,1 written, lanes 2,3 unchanged); ram_ce = 0 in IDLE cycles.
- Both req continuously, fixed priority, MAX_WAIT = 8 → m0 acked repeatedly; m1 acked once cnt1 reaches 8; no cycle with both acks.
- ARB_ROUND_ROBIN_EN defined, both req continuously → acks alternate m0, m1, m0, m1…
- m1 granted, m1_req dropped in the OWN1 cycle → ram_ce = 0, no m1_ack, RAM unchanged, FSM back in IDLE.
- rst asserted mid-OWN0 write → all outputs 0 immediately, write not committed, FSM IDLE after release.
